// File: rtl/mips_cpu_bus_core_if.sv
// Avalon-style memory bus shared by instruction fetch and data access.
// The CPU is the master; memory and peripherals sit behind the slave side.
interface mips_cpu_bus_core_if;
    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/mips_cpu_bus_core.sv
// Multi-cycle MIPS32 integer-subset CPU (FETCH/EXEC/MEM/WB) on a single Avalon bus.
// Starts at 0xBFC00000 and halts once a delay slot completes with a pending target of 0.
module mips_cpu_bus_core (
    input  logic                i_clk,
    input  logic                i_rst_n,
    output logic                o_active,
    output logic [31:0]         o_register_v0,
    mips_cpu_bus_core_if.master bus
);
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, r_npc, r_maddr, r_wdata, r_br_tgt;
    logic        r_br_pend, r_halt_after, r_mem_lw;
    logic [4:0]  r_mem_rt;
    logic [31:0] r_gpr [32];

    logic [31:0] w_ins, w_a, w_b, w_simm, w_zimm, w_pc4, w_eaddr;
    logic [31:0] w_res, w_tgt, w_npc;
    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_rs, w_rt, w_rd, w_sh, w_wa;
    logic [15:0] w_imm;
    logic        w_we, w_taken, w_is_lw, w_is_sw, w_mem, w_slot_halt;

    // The fetched word is only valid during EXEC; it is decoded straight off the bus.
    assign w_ins   = bus.readdata;
    assign w_op    = w_ins[31:26];
    assign w_rs    = w_ins[25:21];
    assign w_rt    = w_ins[20:16];
    assign w_rd    = w_ins[15:11];
    assign w_sh    = w_ins[10:6];
    assign w_fn    = w_ins[5:0];
    assign w_imm   = w_ins[15:0];
    assign w_a     = r_gpr[w_rs];
    assign w_b     = r_gpr[w_rt];
    assign w_simm  = {{16{w_imm[15]}}, w_imm};
    assign w_zimm  = {16'h0000, w_imm};
    assign w_pc4   = r_pc + 32'd4;
    assign w_eaddr = w_a + w_simm;
    assign w_is_lw = (w_op == 6'h23);
    assign w_is_sw = (w_op == 6'h2B);
    assign w_mem   = w_is_lw | w_is_sw;

    // A pending target from the previous instruction makes this one the delay slot.
    assign w_npc       = r_br_pend ? r_br_tgt : w_pc4;
    assign w_slot_halt = r_br_pend && (r_br_tgt == 32'h0000_0000);

    always_comb begin
        w_res   = '0;
        w_wa    = '0;
        w_we    = 1'b0;
        w_taken = 1'b0;
        w_tgt   = '0;
        case (w_op)
            6'h00: begin
                w_wa = w_rd;
                w_we = 1'b1;
                case (w_fn)
                    6'h00: w_res = w_b << w_sh;
                    6'h02: w_res = w_b >> w_sh;
                    6'h03: w_res = $unsigned($signed(w_b) >>> w_sh);
                    6'h08: begin w_we = 1'b0; w_taken = 1'b1; w_tgt = w_a; end
                    6'h09: begin w_res = w_pc4 + 32'd4; w_taken = 1'b1; w_tgt = w_a; end
                    6'h21: w_res = w_a + w_b;
                    6'h23: w_res = w_a - w_b;
                    6'h24: w_res = w_a & w_b;
                    6'h25: w_res = w_a | w_b;
                    6'h26: w_res = w_a ^ w_b;
                    6'h27: w_res = ~(w_a | w_b);
                    6'h2A: w_res = {31'd0, $signed(w_a) < $signed(w_b)};
                    6'h2B: w_res = {31'd0, w_a < w_b};
                    default: w_we = 1'b0;
                endcase
            end
            6'h02: begin w_taken = 1'b1; w_tgt = {w_pc4[31:28], w_ins[25:0], 2'b00}; end
            6'h03: begin
                w_taken = 1'b1;
                w_tgt   = {w_pc4[31:28], w_ins[25:0], 2'b00};
                w_we    = 1'b1;
                w_wa    = 5'd31;
                w_res   = w_pc4 + 32'd4;
            end
            6'h04: begin w_taken = (w_a == w_b); w_tgt = w_pc4 + (w_simm << 2); end
            6'h05: begin w_taken = (w_a != w_b); w_tgt = w_pc4 + (w_simm << 2); end
            6'h09: begin w_we = 1'b1; w_wa = w_rt; w_res = w_a + w_simm; end
            6'h0A: begin w_we = 1'b1; w_wa = w_rt; w_res = {31'd0, $signed(w_a) < $signed(w_simm)}; end
            6'h0B: begin w_we = 1'b1; w_wa = w_rt; w_res = {31'd0, w_a < w_simm}; end
            6'h0C: begin w_we = 1'b1; w_wa = w_rt; w_res = w_a & w_zimm; end
            6'h0D: begin w_we = 1'b1; w_wa = w_rt; w_res = w_a | w_zimm; end
            6'h0E: begin w_we = 1'b1; w_wa = w_rt; w_res = w_a ^ w_zimm; end
            6'h0F: begin w_we = 1'b1; w_wa = w_rt; w_res = {w_imm, 16'h0000}; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_FETCH;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: if (!bus.waitrequest) w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_mem)            w_state_nxt = S_MEM;
                else if (w_slot_halt) w_state_nxt = S_HALT;
                else                  w_state_nxt = S_FETCH;
            end
            S_MEM:   if (!bus.waitrequest) w_state_nxt = S_WB;
            S_WB:    w_state_nxt = r_halt_after ? S_HALT : S_FETCH;
            default: w_state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc         <= 32'hBFC0_0000;
            r_npc        <= '0;
            r_maddr      <= '0;
            r_wdata      <= '0;
            r_br_tgt     <= '0;
            r_br_pend    <= 1'b0;
            r_halt_after <= 1'b0;
            r_mem_lw     <= 1'b0;
            r_mem_rt     <= '0;
            for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
        end else begin
            case (r_state)
                S_EXEC: begin
                    r_br_pend <= w_taken;
                    r_br_tgt  <= w_tgt;
                    if (w_we && (w_wa != 5'd0)) r_gpr[w_wa] <= w_res;
                    if (w_mem) begin
                        r_npc        <= w_npc;
                        r_halt_after <= w_slot_halt;
                        r_maddr      <= w_eaddr & 32'hFFFF_FFFC;
                        r_wdata      <= w_b;
                        r_mem_lw     <= w_is_lw;
                        r_mem_rt     <= w_rt;
                    end else begin
                        r_pc <= w_npc;
                    end
                end
                S_WB: begin
                    if (r_mem_lw && (r_mem_rt != 5'd0)) r_gpr[r_mem_rt] <= bus.readdata;
                    r_pc <= r_npc;
                end
                default: ;
            endcase
        end
    end

    // Requests are gated by reset so nothing is driven while it is held.
    assign bus.read       = i_rst_n && ((r_state == S_FETCH) || ((r_state == S_MEM) && r_mem_lw));
    assign bus.write      = i_rst_n && (r_state == S_MEM) && !r_mem_lw;
    assign bus.address    = (r_state == S_MEM) ? r_maddr : r_pc;
    assign bus.writedata  = r_wdata;
    assign bus.byteenable = 4'b1111;

    assign o_active      = (r_state != S_HALT);
    assign o_register_v0 = r_gpr[2];
endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// Directed programs run from a small boot ROM model with optional waitrequest stalls.
module tb_mips_cpu_bus_core;
    localparam int OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5, OP_ADDIU = 9;
    localparam int OP_XORI = 14, OP_ORI = 13, OP_LUI = 15, OP_LW = 35, OP_SW = 43;
    localparam int FN_SLL = 0, FN_SRL = 2, FN_SRA = 3, FN_JR = 8;
    localparam int FN_ADDU = 33, FN_SUBU = 35, FN_SLT = 42, FN_SLTU = 43;

    logic        clk;
    logic        rst_n;
    logic        active;
    logic [31:0] v0;

    mips_cpu_bus_core_if bus();

    mips_cpu_bus_core dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_active      (active),
        .o_register_v0 (v0),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_r(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] f_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] f_j(input int op, input logic [31:0] addr);
        return {6'(op), addr[27:2]};
    endfunction

    // Bus slave: 64-word memory at 0xBFC00000, g_wait stall cycles per request.
    logic [31:0] mem [0:63];
    int          g_wait = 0;
    int          wcnt = 0;
    bit          rd_pend = 0;
    logic [31:0] rd_val = '0;
    bit          stall_prev = 0;
    logic [31:0] s_addr, s_wd;
    logic        s_rd, s_wr;
    bit          fetch0 = 0;
    int          both_hi = 0;
    int          nwr = 0;
    logic [31:0] last_wa = '0, last_wd = '0;
    logic [3:0]  last_be = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a[31:8] == 24'hBFC000) return mem[a[7:2]];
        return 32'h0;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            wcnt = 0; rd_pend = 0; stall_prev = 0;
            bus.waitrequest = 1'b1;
            bus.readdata    = '0;
        end else begin
            bus.readdata = rd_pend ? rd_val : 32'h0;
            rd_pend = 0;
            if (bus.read && bus.write) both_hi++;
            if (stall_prev) begin
                check("stall_addr", bus.address, s_addr);
                check("stall_rd", {31'd0, bus.read}, {31'd0, s_rd});
                check("stall_wr", {31'd0, bus.write}, {31'd0, s_wr});
                check("stall_wd", bus.writedata, s_wd);
            end
            if (bus.read || bus.write) begin
                if (bus.read && bus.address == 32'h0) fetch0 = 1;
                if (wcnt < g_wait) begin
                    bus.waitrequest = 1'b1;
                    wcnt++;
                    stall_prev = 1;
                    s_addr = bus.address; s_wd = bus.writedata;
                    s_rd = bus.read; s_wr = bus.write;
                end else begin
                    bus.waitrequest = 1'b0;
                    wcnt = 0;
                    stall_prev = 0;
                    if (bus.write) begin
                        if (bus.address[31:8] == 24'hBFC000) mem[bus.address[7:2]] = bus.writedata;
                        nwr++;
                        last_wa = bus.address; last_wd = bus.writedata; last_be = bus.byteenable;
                    end else begin
                        rd_pend = 1;
                        rd_val  = mem_rd(bus.address);
                    end
                end
            end else begin
                bus.waitrequest = 1'b1;
                stall_prev = 0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    endtask

    task automatic load_addu();
        clear_mem();
        mem[0] = f_i(OP_LUI, 0, 8, 'hBFC0);
        mem[1] = f_i(OP_LW, 8, 9, 24);
        mem[2] = f_i(OP_LW, 8, 10, 28);
        mem[3] = f_r(0, 0, 0, 0, FN_JR);
        mem[4] = f_r(9, 10, 2, 0, FN_ADDU);
        mem[6] = 32'h6F;
        mem[7] = 32'h64;
    endtask

    task automatic load_dslot();
        clear_mem();
        mem[0] = f_r(0, 0, 0, 0, FN_JR);
        mem[1] = f_i(OP_ADDIU, 0, 2, 5);
        mem[2] = f_i(OP_ADDIU, 0, 2, 7);
    endtask

    task automatic load_stld();
        clear_mem();
        mem[0] = f_i(OP_LUI, 0, 8, 'hBFC0);
        mem[1] = f_i(OP_LUI, 0, 9, 'hDEAD);
        mem[2] = f_i(OP_ORI, 9, 9, 'hBEEF);
        mem[3] = f_i(OP_SW, 8, 9, 'h40);
        mem[4] = f_i(OP_LW, 8, 2, 'h40);
        mem[5] = f_r(0, 0, 0, 0, FN_JR);
    endtask

    task automatic load_branch();
        clear_mem();
        mem[0]  = f_i(OP_ADDIU, 0, 2, 10);
        mem[1]  = f_i(OP_ADDIU, 0, 3, 10);
        mem[2]  = f_i(OP_BEQ, 2, 3, 2);
        mem[3]  = f_r(2, 3, 2, 0, FN_ADDU);
        mem[4]  = f_i(OP_ADDIU, 2, 2, 1);
        mem[5]  = f_i(OP_BNE, 3, 3, 5);
        mem[6]  = f_i(OP_ADDIU, 2, 2, 100);
        mem[7]  = f_i(OP_ADDIU, 0, 5, -1);
        mem[8]  = f_r(0, 5, 6, 0, FN_SLTU);
        mem[9]  = f_r(5, 0, 7, 0, FN_SLT);
        mem[10] = f_r(2, 6, 2, 0, FN_ADDU);
        mem[11] = f_r(2, 7, 2, 0, FN_ADDU);
        mem[12] = f_r(0, 2, 2, 4, FN_SLL);
        mem[13] = f_i(OP_XORI, 2, 2, 'h0F0F);
        mem[14] = f_r(0, 0, 0, 0, FN_JR);
    endtask

    task automatic load_jal();
        clear_mem();
        mem[0]  = f_j(OP_JAL, 32'hBFC0_0010);
        mem[1]  = f_i(OP_ADDIU, 0, 2, 3);
        mem[2]  = f_r(2, 10, 2, 0, FN_SUBU);
        mem[3]  = f_j(OP_J, 32'hBFC0_0020);
        mem[4]  = f_i(OP_ADDIU, 0, 9, -16);
        mem[5]  = f_r(31, 0, 0, 0, FN_JR);
        mem[6]  = f_r(0, 9, 10, 2, FN_SRA);
        mem[8]  = f_r(0, 9, 11, 28, FN_SRL);
        mem[9]  = f_r(2, 11, 2, 0, FN_ADDU);
        mem[10] = f_r(0, 0, 0, 0, FN_JR);
    endtask

    task automatic run_prog(input int w, input logic [31:0] exp, input string tag);
        int n;
        g_wait = w; fetch0 = 0; both_hi = 0; nwr = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        while (active && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, {31'd0, active}, 32'd0);
        check({tag, "_v0"}, v0, exp);
        repeat (3) @(negedge clk);
        check({tag, "_idle_rd"}, {31'd0, bus.read}, 32'd0);
        check({tag, "_idle_wr"}, {31'd0, bus.write}, 32'd0);
        check({tag, "_v0_frozen"}, v0, exp);
        check({tag, "_no_fetch0"}, {31'd0, fetch0}, 32'd0);
        check({tag, "_rw_excl"}, 32'(both_hi), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        load_dslot();
        repeat (2) @(negedge clk);
        check("rst_read", {31'd0, bus.read}, 32'd0);
        check("rst_write", {31'd0, bus.write}, 32'd0);
        check("rst_wdata", bus.writedata, 32'd0);
        check("rst_active", {31'd0, active}, 32'd1);
        check("rst_v0", v0, 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("first_read", {31'd0, bus.read}, 32'd1);
        check("first_addr", bus.address, 32'hBFC0_0000);
        check("first_active", {31'd0, active}, 32'd1);

        for (int w = 0; w <= 3; w += 3) begin
            load_addu();
            run_prog(w, 32'h0000_00D3, w == 0 ? "addu" : "addu_ws");
            load_dslot();
            run_prog(w, 32'h0000_0005, w == 0 ? "dslot" : "dslot_ws");
            load_stld();
            run_prog(w, 32'hDEAD_BEEF, w == 0 ? "stld" : "stld_ws");
            check("stld_nwr", 32'(nwr), 32'd1);
            check("stld_waddr", last_wa, 32'hBFC0_0040);
            check("stld_wdata", last_wd, 32'hDEAD_BEEF);
            check("stld_be", {28'd0, last_be}, 32'h0000_000F);
            check("stld_mem", mem[16], 32'hDEAD_BEEF);
            load_branch();
            run_prog(w, 32'h0000_08AF, w == 0 ? "branch" : "branch_ws");
            load_jal();
            run_prog(w, 32'h0000_0016, w == 0 ? "jal" : "jal_ws");
        end

        load_branch();
        g_wait = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (9) @(negedge clk);
        check("mid_v0_running", v0, 32'd20);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_read", {31'd0, bus.read}, 32'd0);
        check("abort_write", {31'd0, bus.write}, 32'd0);
        check("abort_v0", v0, 32'd0);
        check("abort_active", {31'd0, active}, 32'd1);
        check("abort_addr", bus.address, 32'hBFC0_0000);
        run_prog(0, 32'h0000_08AF, "rerun");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
